set_assoc_cache_ctrl: RTL and testbench
=======================================

// Module: set_assoc_cache_ctrl
// PURPOSE
// - Parametrised N-way set-associative cache controller between CPU-side request port and word-addressed memory.
// - One data word per line, write-through with write-allocate, true-LRU replacement per set.
// - Valid/ready handshakes on both sides replace the fixed-timing op/address interface of the previous generation.
// PARAMETERS
// - ADDR_W  32   byte address width
// - DATA_W  32   data word width
// - WAYS    4    associativity; power of 2, >= 2
// - SETS    256  sets; power of 2; IDX_W = log2(SETS), TAG_W = ADDR_W - IDX_W - 2
// PORTS
// - clk            in   1       single clock, all logic on posedge
// - rst            in   1       synchronous, active-high reset
// - req_valid      in   1       CPU request present
// - req_ready      out  1       controller accepts request (IDLE only)
// - req_we         in   1       1 = write, 0 = read
// - req_addr       in   ADDR_W  byte address; index = [IDX_W+1:2], tag = [ADDR_W-1:IDX_W+2]
// - req_wdata      in   DATA_W  write data
// - rsp_valid      out  1       one-cycle pulse: request completed (reads and writes); no backpressure
// - rsp_rdata      out  DATA_W  read data, valid with rsp_valid on reads
// - rsp_hit        out  1       1 = request hit in cache, valid with rsp_valid
// - mem_req_valid  out  1       memory request
// - mem_req_ready  in   1       memory accepts request
// - mem_we         out  1       1 = memory write
// - mem_addr       out  ADDR_W  memory byte address (word aligned, req_addr with [1:0]=0)
// - mem_wdata      out  DATA_W  memory write data
// - mem_rsp_valid  in   1       read data returned
// - mem_rdata      in   DATA_W  read data
// BEHAVIOUR
// - Reset: all outputs 0 while rst high; all valid bits cleared; LRU age of way w in every set = w; FSM -> IDLE.
//   req_ready = 1 first cycle after rst low. rst mid-operation aborts any transaction the same edge.
// - FSM: IDLE -> LOOKUP on req_valid&req_ready (addr/we/wdata captured). LOOKUP compares all ways in 1 cycle.
//   LOOKUP read hit  -> RESP. read miss -> MEM_RD. write hit/miss -> MEM_WR.
//   MEM_RD: mem_req_valid=1, mem_we=0 until mem_req_ready; then WAIT_RD until mem_rsp_valid -> fill victim -> RESP.
//   MEM_WR: mem_req_valid=1, mem_we=1, mem_wdata=captured data until mem_req_ready -> RESP. Cache line written in LOOKUP.
//   RESP: rsp_valid=1 for one cycle -> IDLE. req_ready=1 only in IDLE.
// - Latency: read hit rsp_valid 2 cycles after acceptance; max throughput one request per 3 cycles.
//   Read miss: rsp_rdata = mem_rdata, rsp_hit=0. Write: rsp_hit reflects lookup result.
// - mem_addr/mem_we/mem_wdata stable while mem_req_valid high and mem_req_ready low.
// - mem_rsp_valid outside WAIT_RD is ignored (covers late responses after reset).
// - Hit = valid[w] & tag match; >1 hitting way is illegal (assert), lowest index wins.
// - Victim: lowest-index invalid way; else way with age WAYS-1.
// - LRU (age log2(WAYS) bits per way): on hit or fill of way h with age a: age[h]=0, every way with age < a increments,
//   others unchanged. Ages in a set always a permutation of 0..WAYS-1.
// - Write hit updates data in hitting way; write miss writes tag/data/valid into victim; both touch LRU.
// STRUCTURE
// - cache_pkg: FSM state enum (IDLE, LOOKUP, MEM_RD, WAIT_RD, MEM_WR, RESP), derived widths IDX_W/TAG_W helpers.
// - Sub-module cache_lru_set: per-set age update and victim select (inputs valid vector, ages, touched way).
// - Tag/data/valid arrays: flop arrays [WAYS][SETS]; valid reset synchronously.
// TESTING (defaults, all targets set 16)
// - Reset, read 0x40 -> miss, mem read addr 0x40, return 111 -> rsp_rdata=111 rsp_hit=0; reread -> hit=1, no mem_req, 2-cycle latency.
// - Write 0x40=111, 0x440=222, 0xC40=333, 0x1C40=444 -> all misses, 4 mem writes; reads of each hit with written data.
// - Then write 0x840=5000 -> victim is 0x40 line; read 0x40 -> miss; read 0x840 -> hit 5000.
// - Refill 4 lines, read 0x40 (hit) then write 0x840 -> victim 0x440 (LRU), 0x40 still hits.
// - Hold mem_req_ready=0 for 5 cycles on a miss -> mem_req_valid/addr stable, req_ready=0, no rsp_valid.
// - Assert rst during WAIT_RD, then late mem_rsp_valid -> ignored, no rsp_valid; previously valid 0x40 now misses.

Source files
------------

// File: rtl/set_assoc_cache_ctrl_pkg.sv
// Shared types and width helpers for the set-associative cache controller.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MEM_RD,
    WAIT_RD,
    MEM_WR,
    RESP
  } state_t;

  function automatic int unsigned idx_width(input int unsigned sets);
    return $clog2(sets);
  endfunction

  // Byte address minus set index minus the two word-offset bits.
  function automatic int unsigned tag_width(input int unsigned addr_w, input int unsigned sets);
    return addr_w - $clog2(sets) - 2;
  endfunction

endpackage

// File: rtl/set_assoc_cache_ctrl_lru_set.sv
// True-LRU age update and victim selection for one set.
module cache_lru_set #(
  parameter int unsigned WAYS  = 4,
  parameter int unsigned AGE_W = $clog2(WAYS)
) (
  input  logic [WAYS-1:0]            valid,
  input  logic [WAYS-1:0][AGE_W-1:0] ages,
  input  logic [AGE_W-1:0]           touch,
  output logic [WAYS-1:0][AGE_W-1:0] new_ages,
  output logic [AGE_W-1:0]           victim
);

  // Ways younger than the touched one age by one; the touched way becomes youngest.
  always_comb begin
    new_ages = ages;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (AGE_W'(w) == touch) begin
        new_ages[w] = '0;
      end else if (ages[w] < ages[touch]) begin
        new_ages[w] = ages[w] + AGE_W'(1);
      end
    end
  end

  logic found;

  always_comb begin
    victim = '0;
    found  = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!found && !valid[w]) begin
        victim = AGE_W'(w);
        found  = 1'b1;
      end
    end
    if (!found) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (ages[w] == AGE_W'(WAYS - 1)) begin
          victim = AGE_W'(w);
        end
      end
    end
  end

endmodule

// File: rtl/set_assoc_cache_ctrl.sv
// N-way set-associative write-through/write-allocate cache controller with
// valid/ready CPU and memory ports and true-LRU replacement.
module set_assoc_cache_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned WAYS   = 4,
  parameter int unsigned SETS   = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_hit,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned IDX_W = idx_width(SETS);
  localparam int unsigned TAG_W = tag_width(ADDR_W, SETS);
  localparam int unsigned AGE_W = $clog2(WAYS);

  state_t            state;
  logic [ADDR_W-1:0] cap_addr;
  logic              cap_we;
  logic [DATA_W-1:0] cap_wdata;

  logic [TAG_W-1:0]             tag_mem  [WAYS][SETS];
  logic [DATA_W-1:0]            data_mem [WAYS][SETS];
  logic                         valid_mem[WAYS][SETS];
  logic [WAYS-1:0][AGE_W-1:0]   age_mem  [SETS];

  logic [IDX_W-1:0]           idx;
  logic [TAG_W-1:0]           tag;
  logic [WAYS-1:0]            set_valid;
  logic [WAYS-1:0]            hit_vec;
  logic                       hit;
  logic [AGE_W-1:0]           hit_way;
  logic [AGE_W-1:0]           victim;
  logic [AGE_W-1:0]           touch;
  logic [WAYS-1:0][AGE_W-1:0] new_ages;
  logic                       fill;
  logic                       wr_lookup;
  logic                       line_wr;
  logic                       lru_upd;

  assign idx = cap_addr[IDX_W+1:2];
  assign tag = cap_addr[ADDR_W-1:IDX_W+2];

  always_comb begin
    set_valid = '0;
    hit_vec   = '0;
    hit       = 1'b0;
    hit_way   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      set_valid[w] = valid_mem[w][idx];
      hit_vec[w]   = valid_mem[w][idx] && (tag_mem[w][idx] == tag);
    end
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (hit_vec[w] && !hit) begin
        hit     = 1'b1;
        hit_way = AGE_W'(w);
      end
    end
  end

  // One way index serves both the line write and the LRU touch: the hitting
  // way on a lookup hit, otherwise the victim (write miss or read fill).
  assign touch     = (state == LOOKUP && hit) ? hit_way : victim;
  assign fill      = (state == WAIT_RD) && mem_rsp_valid;
  assign wr_lookup = (state == LOOKUP) && cap_we;
  assign line_wr   = fill || wr_lookup;
  assign lru_upd   = line_wr || ((state == LOOKUP) && hit);

  cache_lru_set #(
    .WAYS (WAYS),
    .AGE_W(AGE_W)
  ) u_lru (
    .valid   (set_valid),
    .ages    (age_mem[idx]),
    .touch   (touch),
    .new_ages(new_ages),
    .victim  (victim)
  );

  always_ff @(posedge clk) begin
    if (line_wr && !rst) begin
      tag_mem[touch][idx]  <= tag;
      data_mem[touch][idx] <= fill ? mem_rdata : cap_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          valid_mem[w][s] <= 1'b0;
          age_mem[s][w]   <= AGE_W'(w);
        end
      end
    end else begin
      if (line_wr) valid_mem[touch][idx] <= 1'b1;
      if (lru_upd) age_mem[idx] <= new_ages;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      req_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_hit       <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      cap_addr      <= '0;
      cap_we        <= 1'b0;
      cap_wdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            cap_addr  <= req_addr;
            cap_we    <= req_we;
            cap_wdata <= req_wdata;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          rsp_hit <= hit;
          if (cap_we) begin
            mem_req_valid <= 1'b1;
            mem_we        <= 1'b1;
            mem_addr      <= cap_addr & ~ADDR_W'(3);
            mem_wdata     <= cap_wdata;
            state         <= MEM_WR;
          end else if (hit) begin
            rsp_rdata <= data_mem[hit_way][idx];
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            mem_req_valid <= 1'b1;
            mem_we        <= 1'b0;
            mem_addr      <= cap_addr & ~ADDR_W'(3);
            state         <= MEM_RD;
          end
        end
        MEM_RD: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT_RD;
          end
        end
        WAIT_RD: begin
          if (mem_rsp_valid) begin
            rsp_rdata <= mem_rdata;
            rsp_hit   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        MEM_WR: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            mem_we        <= 1'b0;
            rsp_valid     <= 1'b1;
            state         <= RESP;
          end
        end
        RESP: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_single_hit: assert property (@(posedge clk) disable iff (rst)
    (state == LOOKUP) |-> $onehot0(hit_vec));

endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Directed bench for set_assoc_cache_ctrl: vector table plus stall and reset-abort sequences.
module tb_set_assoc_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_hit;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  set_assoc_cache_ctrl #(
    .ADDR_W(32),
    .DATA_W(32),
    .WAYS  (4),
    .SETS  (256)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_hit      (rsp_hit),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rdata    (mem_rdata)
  );

  typedef struct {
    bit          rst_before;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_data;
    bit          exp_hit;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[24];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    repeat (3) @(negedge clk);
    chkb("rst_req_ready", req_ready, 1'b0);
    chkb("rst_rsp_valid", rsp_valid, 1'b0);
    chkb("rst_mem_req_valid", mem_req_valid, 1'b0);
    chkb("rst_mem_we", mem_we, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chkb("req_ready_after_rst", req_ready, 1'b1);
  endtask

  task automatic wait_ready(input string nm);
    int cyc;
    cyc = 0;
    while (!req_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chkb({nm, "_req_ready"}, req_ready, 1'b1);
  endtask

  // Issues one request and plays the memory side, checking the memory request
  // fields, the response, and read-hit latency (cycles counted from the accept cycle).
  task automatic transact(input vec_t v, input string nm);
    int lat;
    bit mem_seen;
    bit rsp_seen;
    wait_ready(nm);
    req_valid = 1'b1;
    req_we    = v.we;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    mem_seen = 1'b0;
    rsp_seen = 1'b0;
    while (!rsp_seen && lat < 50) begin
      if (rsp_valid) begin
        rsp_seen = 1'b1;
      end else if (mem_req_valid && !mem_seen) begin
        mem_seen = 1'b1;
        chk({nm, "_mem_addr"}, mem_addr, v.addr & ~32'd3);
        chkb({nm, "_mem_we"}, mem_we, v.we);
        if (v.we) chk({nm, "_mem_wdata"}, mem_wdata, v.wdata);
        mem_req_ready = 1'b1;
        @(negedge clk);
        lat++;
        mem_req_ready = 1'b0;
        if (!v.we) begin
          mem_rsp_valid = 1'b1;
          mem_rdata = v.mem_data;
          @(negedge clk);
          lat++;
          mem_rsp_valid = 1'b0;
        end
      end else begin
        @(negedge clk);
        lat++;
      end
    end
    chkb({nm, "_rsp_valid"}, rsp_seen, 1'b1);
    chkb({nm, "_rsp_hit"}, rsp_hit, v.exp_hit);
    if (!v.we) chk({nm, "_rdata"}, rsp_rdata, v.exp_rdata);
    chkb({nm, "_mem_req"}, mem_seen, v.we || !v.exp_hit);
    if (!v.we && v.exp_hit) chk({nm, "_latency"}, lat, 32'd2);
    @(negedge clk);
    chkb({nm, "_rsp_pulse"}, rsp_valid, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   cyc;

    vecs[0]  = '{1'b1, 1'b0, 32'h40,   32'd0,    32'd111, 1'b0, 32'd111};
    vecs[1]  = '{1'b0, 1'b0, 32'h40,   32'd0,    32'd0,   1'b1, 32'd111};
    vecs[2]  = '{1'b1, 1'b1, 32'h40,   32'd111,  32'd0,   1'b0, 32'd0};
    vecs[3]  = '{1'b0, 1'b1, 32'h440,  32'd222,  32'd0,   1'b0, 32'd0};
    vecs[4]  = '{1'b0, 1'b1, 32'hC40,  32'd333,  32'd0,   1'b0, 32'd0};
    vecs[5]  = '{1'b0, 1'b1, 32'h1C40, 32'd444,  32'd0,   1'b0, 32'd0};
    vecs[6]  = '{1'b0, 1'b0, 32'h40,   32'd0,    32'd0,   1'b1, 32'd111};
    vecs[7]  = '{1'b0, 1'b0, 32'h440,  32'd0,    32'd0,   1'b1, 32'd222};
    vecs[8]  = '{1'b0, 1'b0, 32'hC40,  32'd0,    32'd0,   1'b1, 32'd333};
    vecs[9]  = '{1'b0, 1'b0, 32'h1C40, 32'd0,    32'd0,   1'b1, 32'd444};
    vecs[10] = '{1'b0, 1'b1, 32'h840,  32'd5000, 32'd0,   1'b0, 32'd0};
    vecs[11] = '{1'b0, 1'b0, 32'h40,   32'd0,    32'd777, 1'b0, 32'd777};
    vecs[12] = '{1'b0, 1'b0, 32'h840,  32'd0,    32'd0,   1'b1, 32'd5000};
    vecs[13] = '{1'b0, 1'b0, 32'h440,  32'd0,    32'd888, 1'b0, 32'd888};
    vecs[14] = '{1'b1, 1'b1, 32'h40,   32'd11,   32'd0,   1'b0, 32'd0};
    vecs[15] = '{1'b0, 1'b1, 32'h440,  32'd22,   32'd0,   1'b0, 32'd0};
    vecs[16] = '{1'b0, 1'b1, 32'hC40,  32'd33,   32'd0,   1'b0, 32'd0};
    vecs[17] = '{1'b0, 1'b1, 32'h1C40, 32'd44,   32'd0,   1'b0, 32'd0};
    vecs[18] = '{1'b0, 1'b0, 32'h40,   32'd0,    32'd0,   1'b1, 32'd11};
    vecs[19] = '{1'b0, 1'b1, 32'h840,  32'd55,   32'd0,   1'b0, 32'd0};
    vecs[20] = '{1'b0, 1'b0, 32'h40,   32'd0,    32'd0,   1'b1, 32'd11};
    vecs[21] = '{1'b0, 1'b0, 32'hC40,  32'd0,    32'd0,   1'b1, 32'd33};
    vecs[22] = '{1'b0, 1'b0, 32'h440,  32'd0,    32'd99,  1'b0, 32'd99};
    vecs[23] = '{1'b0, 1'b1, 32'h840,  32'd66,   32'd0,   1'b1, 32'd0};

    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rdata = '0;

    for (int i = 0; i < 24; i++) begin
      if (vecs[i].rst_before) apply_reset();
      transact(vecs[i], $sformatf("v%0d", i));
    end

    // Memory back-pressure on a read miss in an untouched set.
    wait_ready("stall");
    req_valid = 1'b1;
    req_we = 1'b0;
    req_addr = 32'h80;
    @(negedge clk);
    cyc = 0;
    while (!mem_req_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chkb("stall_mem_req_seen", mem_req_valid, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chkb("stall_mem_req_valid", mem_req_valid, 1'b1);
      chk("stall_mem_addr", mem_addr, 32'h80);
      chkb("stall_mem_we", mem_we, 1'b0);
      chkb("stall_req_ready", req_ready, 1'b0);
      chkb("stall_rsp_valid", rsp_valid, 1'b0);
    end
    req_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chkb("stall_mem_req_drop", mem_req_valid, 1'b0);
    mem_rsp_valid = 1'b1;
    mem_rdata = 32'hABCD;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chkb("stall_rsp_valid_end", rsp_valid, 1'b1);
    chk("stall_rdata", rsp_rdata, 32'hABCD);
    chkb("stall_rsp_hit", rsp_hit, 1'b0);
    @(negedge clk);

    // Reset while waiting for read data; a late response must be ignored.
    wait_ready("abort");
    req_valid = 1'b1;
    req_we = 1'b0;
    req_addr = 32'h100;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 0;
    while (!mem_req_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chkb("abort_mem_req_seen", mem_req_valid, 1'b1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chkb("abort_rst_rsp_valid", rsp_valid, 1'b0);
    chkb("abort_rst_mem_req_valid", mem_req_valid, 1'b0);
    chkb("abort_rst_req_ready", req_ready, 1'b0);
    rst = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rdata = 32'd999;
    @(negedge clk);
    chkb("abort_late_rsp_valid0", rsp_valid, 1'b0);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chkb("abort_late_rsp_valid", rsp_valid, 1'b0);
      chkb("abort_idle_ready", req_ready, 1'b1);
      @(negedge clk);
    end
    v = '{1'b0, 1'b0, 32'h40, 32'd0, 32'd321, 1'b0, 32'd321};
    transact(v, "post_abort_0x40");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
